// File: rtl/pair_accumulate.sv
// Pair accumulator: sums both elements of each upstream pair into a running total
// and counts pairs, presenting (sum, count) downstream with a valid/ready handshake.
module pair_accumulate (
    input  logic               _clock,
    input  logic               _reset,
    input  logic               _start,
    output logic               _in_start,
    input  logic               _in_valid,
    output logic               _in_ready,
    input  logic               _in_done,
    input  logic signed [31:0] _in_0,
    input  logic signed [31:0] _in_1,
    input  logic               _ready,
    output logic               _valid,
    output logic               _done,
    output logic signed [31:0] _0,
    output logic signed [31:0] _1
);

    // state | meaning
    // IDLE  | after reset, waiting for _start; upstream ignored
    // ARM   | one cycle after _in_start pulse; stale upstream flags ignored
    // RUN   | accepting pairs until upstream reports done
    // DONE  | run finished; pending result drains, _done held
    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               in_start_q, in_start_d;
    logic               handshake;

    assign _in_ready = (state_q == RUN) && (!valid_q || _ready);
    assign handshake = _in_valid && _in_ready;

    assign _in_start = in_start_q;
    assign _valid    = valid_q;
    assign _done     = done_q;
    // The output registers are the accumulator and count themselves.
    assign _0        = acc_q;
    assign _1        = cnt_q;

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            in_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            in_start_q <= in_start_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        done_d     = done_q;
        in_start_d = 1'b0;

        // _start overrides any handshake or _in_done in the same cycle.
        if (_start) begin
            state_d    = ARM;
            acc_d      = '0;
            cnt_d      = '0;
            valid_d    = 1'b0;
            done_d     = 1'b0;
            in_start_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                end
                ARM: begin
                    state_d = RUN;
                end
                RUN: begin
                    if (handshake) begin
                        acc_d   = acc_q + _in_0 + _in_1;
                        cnt_d   = cnt_q + 32'sd1;
                        valid_d = 1'b1;
                    end else begin
                        if (_ready) begin
                            valid_d = 1'b0;
                        end
                        if (_in_done) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (_ready) begin
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_accumulate.sv
// Bench for pair_accumulate: table of pairs with expected (sum, count), a scoreboard
// queue filled on each upstream handshake and drained by a negedge monitor.
module tb_pair_accumulate;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               s_start = 1'b0;
    logic               in_start;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic               in_done = 1'b0;
    logic signed [31:0] in_0 = '0;
    logic signed [31:0] in_1 = '0;
    logic               rdy = 1'b1;
    logic               o_valid;
    logic               o_done;
    logic signed [31:0] o_0;
    logic signed [31:0] o_1;

    int          tests = 0;
    int          fails = 0;
    bit          stall_mode = 1'b0;
    int          stall_cnt = 0;
    logic [63:0] sb[$];
    vec_t        tbl[7];

    pair_accumulate dut (
        ._clock   (clk),
        ._reset   (rst_n),
        ._start   (s_start),
        ._in_start(in_start),
        ._in_valid(in_valid),
        ._in_ready(in_ready),
        ._in_done (in_done),
        ._in_0    (in_0),
        ._in_1    (in_1),
        ._ready   (rdy),
        ._valid   (o_valid),
        ._done    (o_done),
        ._0       (o_0),
        ._1       (o_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream: decide _ready for the coming edge, then check any presented result.
    initial begin
        forever begin
            @(negedge clk);
            if (stall_mode) begin
                if (o_valid) begin
                    if (stall_cnt < 3) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end else begin
                        rdy = 1'b1;
                        stall_cnt = 0;
                    end
                end else begin
                    rdy = 1'b0;
                end
            end else begin
                rdy = 1'b1;
            end
            #1;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, o_valid}, 32'd0);
                end else begin
                    chk("out_sum", o_0, sb[0][63:32]);
                    chk("out_count", o_1, sb[0][31:0]);
                    if (!rdy) chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
                    else void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send_pair(input vec_t v, input bit with_done);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_0 = v.a;
        in_1 = v.b;
        if (with_done) in_done = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #2;
            if (in_ready) begin
                sb.push_back({v.e0, v.e1});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk("handshake_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end
    endtask

    // Leaves the bench one step after the ARM->RUN edge.
    task automatic pulse_start();
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        chk("start_in_start", {31'd0, in_start}, 32'd1);
        chk("start_valid", {31'd0, o_valid}, 32'd0);
        chk("start_done", {31'd0, o_done}, 32'd0);
        chk("start_count", o_1, 32'd0);
        chk("start_sum", o_0, 32'd0);
        chk("arm_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("in_start_pulse_end", {31'd0, in_start}, 32'd0);
    endtask

    task automatic wait_done_drain();
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            #3;
            if (o_done && sb.size() == 0 && !o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        chk("done_flag", {31'd0, o_done}, 32'd1);
        chk("done_in_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic run_stream(input bit stall, input bit done_with_last);
        stall_mode = stall;
        stall_cnt = 0;
        pulse_start();
        in_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pair(tbl[i], done_with_last && (i == 4));
            if (i == 0) chk("no_early_done", {31'd0, o_done}, 32'd0);
        end
        in_done = 1'b1;
        wait_done_drain();
        chk("final_sum", o_0, 32'd40);
        chk("final_count", o_1, 32'd5);
        stall_mode = 1'b0;
    endtask

    initial begin
        tbl[0] = '{32'd0, 32'd0, 32'd0, 32'd1};
        tbl[1] = '{32'd2, 32'd2, 32'd4, 32'd2};
        tbl[2] = '{32'd4, 32'd4, 32'd12, 32'd3};
        tbl[3] = '{32'd6, 32'd6, 32'd24, 32'd4};
        tbl[4] = '{32'd8, 32'd8, 32'd40, 32'd5};
        tbl[5] = '{32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'd1};
        tbl[6] = '{32'd5, 32'd0, 32'h8000_0005, 32'd2};

        #12;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_in_start", {31'd0, in_start}, 32'd0);
        chk("rst_sum", o_0, 32'd0);
        chk("rst_count", o_1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // IDLE ignores upstream.
        in_valid = 1'b1;
        in_done = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        chk("idle_valid", {31'd0, o_valid}, 32'd0);
        chk("idle_done", {31'd0, o_done}, 32'd0);
        in_valid = 1'b0;

        // Basic stream; in_done stays high across the next start (stale during ARM).
        run_stream(1'b0, 1'b0);
        run_stream(1'b0, 1'b1);
        run_stream(1'b1, 1'b0);

        // Empty run: in_done already high when RUN is reached.
        pulse_start();
        wait_done_drain();
        chk("empty_count", o_1, 32'd0);
        chk("empty_sum", o_0, 32'd0);

        // Wrap-around.
        pulse_start();
        in_done = 1'b0;
        send_pair(tbl[5], 1'b0);
        send_pair(tbl[6], 1'b0);
        in_done = 1'b1;
        wait_done_drain();
        chk("wrap_sum", o_0, 32'h8000_0005);
        chk("wrap_count", o_1, 32'd2);

        // Reset after the second result, then a full rerun.
        pulse_start();
        in_done = 1'b0;
        send_pair(tbl[0], 1'b0);
        send_pair(tbl[1], 1'b0);
        @(negedge clk);
        #3;
        chk("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_sum", o_0, 32'd0);
        chk("mid_rst_count", o_1, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("post_rst_valid", {31'd0, o_valid}, 32'd0);
        in_valid = 1'b0;
        run_stream(1'b0, 1'b0);

        // _start in the same cycle as a handshake discards that pair.
        pulse_start();
        in_done = 1'b0;
        send_pair(tbl[0], 1'b0);
        in_valid = 1'b1;
        in_0 = 32'sd2;
        in_1 = 32'sd2;
        s_start = 1'b1;
        @(negedge clk);
        #2;
        chk("collide_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        s_start = 1'b0;
        in_valid = 1'b0;
        chk("collide_in_start", {31'd0, in_start}, 32'd1);
        chk("collide_valid", {31'd0, o_valid}, 32'd0);
        chk("collide_count", o_1, 32'd0);
        @(posedge clk);
        #1;
        chk("collide_pulse_end", {31'd0, in_start}, 32'd0);
        send_pair('{32'd3, 32'd4, 32'd7, 32'd1}, 1'b0);
        in_done = 1'b1;
        wait_done_drain();
        chk("collide_final_count", o_1, 32'd1);
        chk("collide_final_sum", o_0, 32'd7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pair_accumulate.md
PAIR_ACCUMULATE -- requirements
Module: pair_accumulate

Interface
REQ-001 SHALL have port _clock, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-002 SHALL have port _reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port _start, input, 1 bit: high for one cycle begins a new accumulation run.
REQ-004 SHALL have port _in_start, output reg, 1 bit: start pulse to the upstream generator.
REQ-005 SHALL have port _in_valid, input, 1 bit: the upstream pair is valid.
REQ-006 SHALL have port _in_ready, output, 1 bit: this block accepts the upstream pair this cycle.
REQ-007 SHALL have port _in_done, input, 1 bit: upstream generator is exhausted.
REQ-008 SHALL have port _in_0, input, signed 32 bits: upstream tuple element 0.
REQ-009 SHALL have port _in_1, input, signed 32 bits: upstream tuple element 1.
REQ-010 SHALL have port _ready, input, 1 bit: downstream can take output.
REQ-011 SHALL have port _valid, output reg, 1 bit: _0/_1 hold a valid result.
REQ-012 SHALL have port _done, output reg, 1 bit: run complete, no further output.
REQ-013 SHALL have port _0, output reg, signed 32 bits: running sum.
REQ-014 SHALL have port _1, output reg, signed 32 bits: count of pairs consumed.

Function
REQ-015 SHALL implement states IDLE, ARM, RUN and DONE in a registered state variable.
REQ-016 IDLE SHALL hold all outputs and ignore the upstream ports until _start.
REQ-017 On _start, from any state, the block SHALL:
  - clear the accumulator and the count;
  - clear _valid and _done;
  - drive _in_start=1 for exactly the next cycle;
  - enter ARM.
REQ-018 ARM SHALL last one cycle, SHALL ignore _in_done and _in_valid (they may be stale from the previous run), and SHALL then enter RUN.
REQ-019 _in_ready SHALL be combinational and SHALL equal (state==RUN) && (!_valid || _ready).
REQ-020 On an upstream handshake (_in_valid && _in_ready), the block SHALL register the following in the same edge:
  - acc_next = acc + _in_0 + _in_1, 32-bit two's-complement wrap, no saturation;
  - count_next = count + 1, wrapping at 32 bits;
  - _0 <= acc_next;
  - _1 <= count_next;
  - _valid <= 1.
REQ-021 Latency SHALL be one cycle from the upstream handshake to the corresponding _valid.
REQ-022 While _valid=1 and _ready=0, _0, _1 and _valid SHALL hold, and _in_ready SHALL be 0.
REQ-023 When _ready=1 and no new result is produced that cycle, _valid SHALL fall to 0.
REQ-024 In RUN, if _in_done=1 and no handshake occurs, the block SHALL enter DONE on that edge.
REQ-025 If _in_valid and _in_done are both high in the same RUN cycle, the pair SHALL be consumed first and _in_done SHALL be honoured on a later cycle.
REQ-026 In DONE, _done SHALL become 1 on entry.
REQ-027 In DONE, _done SHALL stay 1 until _start or reset.
REQ-028 In DONE, a pending result SHALL remain valid until _ready.
REQ-029 In DONE, _in_ready SHALL be 0.
REQ-030 For an empty upstream sequence, the block SHALL emit no valid result and SHALL assert _done with _1=0.
REQ-031 _start SHALL take precedence over every other same-cycle event, including a handshake or _in_done.

Reset
REQ-032 While _reset=0, the block SHALL asynchronously set:
  - state to IDLE;
  - _valid, _done and _in_start to 0;
  - _0, _1, the accumulator and the count to 0.
REQ-033 Reset mid-run SHALL abandon the run with no further output; _in_ready SHALL be 0 until the next _start reaches RUN.

Verification
REQ-034 Upstream stream (0,0),(2,2),(4,4),(6,6),(8,8), then _in_done, with _ready=1 -> (_0,_1) = (0,1),(4,2),(12,3),(24,4),(40,5), then _done=1.
REQ-035 Same stream with _ready=0 for 3 cycles after each _valid -> identical values, each held for the stall, and _in_ready=0 throughout each stall.
REQ-036 _in_done=1 in the first RUN cycle with no data -> no _valid, and _done=1 with _1=0; a stale _in_done during ARM is ignored.
REQ-037 Pairs (0x7FFFFFFF,1) then (5,0) -> _0 = 0x80000000 then 0x80000005, _1 = 1 then 2.
REQ-038 _reset low after the 2nd result of the REQ-034 stream -> all outputs 0 immediately; a subsequent _start reruns and reproduces the REQ-034 sequence exactly.
REQ-039 _start asserted in the same cycle as a handshake -> that pair is discarded, _in_start pulses, and the count restarts at 1.
